ysyx_22040759_mem_arbiter: RTL and testbench

Two-port-to-one memory arbiter and sequencer for the NPC core. It shares the single unified memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU), and serializes one transaction at a time through a request/response FSM. The IFU and LSU sit upstream; the memory model (DPI-backed) sits downstream.

---
 rtl/ysyx_22040759_mem_arbiter_pkg.sv | 22 ++
 rtl/ysyx_22040759_mem_arbiter_arb_prio.sv | 51 +++++
 rtl/ysyx_22040759_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_ysyx_22040759_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_define
// Brief    : Shared encodings for the unified memory arbiter.
// Revision : 1.0
// ============================================================================
package ysyx_22040759_define;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   localparam int unsigned ARB_STARVE_MAX_DFLT = 4;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040759_mem_arbiter_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_arb_prio
// Brief    : LSU-priority winner select with an IFU anti-starvation counter.
// Revision : 1.0
// ============================================================================
module ysyx_22040759_arb_prio
   import ysyx_22040759_define::*;
#(
   parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DFLT
) (
   input  logic clk,
   input  logic rst,
   input  logic idle_i,
   input  logic if_valid_i,
   input  logic ls_valid_i,
   output logic if_grant_o,
   output logic ls_grant_o
);

   localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;
   logic             if_forced;

   assign if_forced  = if_valid_i && (starve_cnt_q == CNT_MAX);
   assign ls_grant_o = idle_i && ls_valid_i && !if_forced;
   assign if_grant_o = idle_i && if_valid_i && (!ls_valid_i || if_forced);

   // Only LSU grants that overtake a waiting IFU count towards starvation.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (if_grant_o || (idle_i && !if_valid_i)) begin
         starve_cnt_d = '0;
      end else if (ls_grant_o && if_valid_i && (starve_cnt_q != CNT_MAX)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040759_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_mem_arbiter
// Brief    : Serializes IFU and LSU requests onto one memory port.
// Revision : 1.0
// ============================================================================
module ysyx_22040759_mem_arbiter
   import ysyx_22040759_define::*;
#(
   parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DFLT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [63:0] if_addr,
   output logic        if_resp_valid,
   output logic [63:0] if_rdata,
   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic [63:0] ls_addr,
   input  logic        ls_wen,
   input  logic [63:0] ls_wdata,
   input  logic [7:0]  ls_wmask,
   output logic        ls_resp_valid,
   output logic [63:0] ls_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_addr,
   output logic        mem_wen,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_rdata
);

   arb_state_e  state_q;
   logic        owner_q;
   logic        req_valid_q;
   logic [63:0] addr_q;
   logic        wen_q;
   logic [63:0] wdata_q;
   logic [7:0]  wmask_q;
   logic        if_resp_q;
   logic        ls_resp_q;
   logic [63:0] if_rdata_q;
   logic [63:0] ls_rdata_q;
   logic        if_grant;
   logic        ls_grant;

   ysyx_22040759_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk        (clk),
      .rst        (rst),
      .idle_i     (state_q == ARB_IDLE),
      .if_valid_i (if_req_valid),
      .ls_valid_i (ls_req_valid),
      .if_grant_o (if_grant),
      .ls_grant_o (ls_grant)
   );

   assign if_req_ready  = if_grant;
   assign ls_req_ready  = ls_grant;
   assign mem_req_valid = req_valid_q;
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;
   assign if_resp_valid = if_resp_q;
   assign ls_resp_valid = ls_resp_q;
   assign if_rdata      = if_rdata_q;
   assign ls_rdata      = ls_rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWN_IF;
         req_valid_q <= 1'b0;
         addr_q      <= 64'h0;
         wen_q       <= 1'b0;
         wdata_q     <= 64'h0;
         wmask_q     <= 8'h0;
         if_resp_q   <= 1'b0;
         ls_resp_q   <= 1'b0;
         if_rdata_q  <= 64'h0;
         ls_rdata_q  <= 64'h0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (ls_grant) begin
                  owner_q     <= OWN_LS;
                  addr_q      <= ls_addr;
                  wen_q       <= ls_wen;
                  wdata_q     <= ls_wdata;
                  wmask_q     <= ls_wmask;
                  req_valid_q <= 1'b1;
                  state_q     <= ARB_ISSUE;
               end else if (if_grant) begin
                  owner_q     <= OWN_IF;
                  addr_q      <= if_addr;
                  wen_q       <= 1'b0;
                  wdata_q     <= 64'h0;
                  wmask_q     <= 8'h0;
                  req_valid_q <= 1'b1;
                  state_q     <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (mem_req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               // A write acknowledge carries no data back to the LSU.
               if (mem_resp_valid) begin
                  if (owner_q == OWN_LS) begin
                     ls_rdata_q <= wen_q ? 64'h0 : mem_rdata;
                     ls_resp_q  <= 1'b1;
                  end else begin
                     if_rdata_q <= mem_rdata;
                     if_resp_q  <= 1'b1;
                  end
                  state_q <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if_resp_q <= 1'b0;
               ls_resp_q <= 1'b0;
               state_q   <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040759_mem_arbiter
// Brief    : Directed, table-driven bench for the unified memory arbiter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ysyx_22040759_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid, if_req_ready, if_resp_valid;
   logic [63:0] if_addr, if_rdata;
   logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
   logic [63:0] ls_addr, ls_wdata, ls_rdata;
   logic [7:0]  ls_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   always #5 clk = ~clk;

   ysyx_22040759_mem_arbiter #(.STARVE_MAX(4)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_valid   (if_req_valid),
      .if_req_ready   (if_req_ready),
      .if_addr        (if_addr),
      .if_resp_valid  (if_resp_valid),
      .if_rdata       (if_rdata),
      .ls_req_valid   (ls_req_valid),
      .ls_req_ready   (ls_req_ready),
      .ls_addr        (ls_addr),
      .ls_wen         (ls_wen),
      .ls_wdata       (ls_wdata),
      .ls_wmask       (ls_wmask),
      .ls_resp_valid  (ls_resp_valid),
      .ls_rdata       (ls_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata)
   );

   typedef struct {
      logic        is_ls;
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic [63:0] mrdata;
      int          stall;
      logic        exp_wen;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_wmask;
      logic [63:0] exp_rdata;
   } txn_t;

   typedef struct {
      logic ifv;
      logic lsv;
      logic exp_ifr;
      logic exp_lsr;
   } arb_t;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [63:0] exp_if_rdata = 64'h0;
   logic [63:0] exp_ls_rdata = 64'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered at IDLE, one time unit after a rising edge; leaves in IDLE.
   task automatic run_txn(input txn_t t);
      if_addr  = t.addr;
      ls_addr  = ~t.addr;
      ls_wen   = t.wen;
      ls_wdata = t.wdata;
      ls_wmask = t.wmask;
      if (t.is_ls) begin
         ls_addr      = t.addr;
         ls_req_valid = 1'b1;
      end else begin
         if_req_valid = 1'b1;
      end
      #1;
      check("txn_if_ready", if_req_ready, !t.is_ls);
      check("txn_ls_ready", ls_req_ready, t.is_ls);
      step();
      if_req_valid   = 1'b0;
      ls_req_valid   = 1'b0;
      if_addr        = 64'h0;
      ls_addr        = 64'h0;
      ls_wdata       = ~t.wdata;
      ls_wmask       = ~t.wmask;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
      for (int k = 0; k <= t.stall; k++) begin
         if (k == t.stall) mem_req_ready = 1'b1;
         #1;
         check("issue_req_valid", mem_req_valid, 1'b1);
         check("issue_addr", mem_addr, t.addr);
         check("issue_wen", mem_wen, t.exp_wen);
         check("issue_wdata", mem_wdata, t.exp_wdata);
         check("issue_wmask", mem_wmask, t.exp_wmask);
         check("issue_resp", {if_resp_valid, ls_resp_valid}, 2'b00);
         step();
      end
      mem_req_ready = 1'b0;
      mem_rdata     = t.mrdata;
      #1;
      check("wait_req_valid", mem_req_valid, 1'b0);
      check("wait_resp", {if_resp_valid, ls_resp_valid}, 2'b00);
      step();
      mem_resp_valid = 1'b0;
      mem_rdata      = 64'h0;
      if (t.is_ls) exp_ls_rdata = t.exp_rdata;
      else         exp_if_rdata = t.exp_rdata;
      #1;
      check("resp_if_valid", if_resp_valid, !t.is_ls);
      check("resp_ls_valid", ls_resp_valid, t.is_ls);
      check("resp_if_rdata", if_rdata, exp_if_rdata);
      check("resp_ls_rdata", ls_rdata, exp_ls_rdata);
      step();
      check("idle_resp", {if_resp_valid, ls_resp_valid}, 2'b00);
   endtask

   // Entered in ISSUE just after the grant edge; finishes the transaction with ready high.
   task automatic complete(input logic is_ls, input logic [63:0] exp_addr, input logic [63:0] rd);
      mem_req_ready = 1'b1;
      #1;
      check("busy_addr", mem_addr, exp_addr);
      check("busy_issue_ready", {if_req_ready, ls_req_ready}, 2'b00);
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = rd;
      #1;
      check("busy_wait_ready", {if_req_ready, ls_req_ready}, 2'b00);
      step();
      mem_resp_valid = 1'b0;
      if (is_ls) exp_ls_rdata = rd;
      else       exp_if_rdata = rd;
      #1;
      check("busy_resp_ready", {if_req_ready, ls_req_ready}, 2'b00);
      check("busy_resp_valid", {if_resp_valid, ls_resp_valid}, {!is_ls, is_ls});
      check("busy_if_rdata", if_rdata, exp_if_rdata);
      check("busy_ls_rdata", ls_rdata, exp_ls_rdata);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t txns[5];
      arb_t arbs[4];
      logic exp_ls;

      txns[0] = '{1'b0, 64'h8000_0000, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'h0010_0073, 0,
                  1'b0, 64'h0, 8'h00, 64'h0010_0073};
      txns[1] = '{1'b1, 64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 64'hFFFF_0000_FFFF_0000, 3,
                  1'b1, 64'h1122_3344_5566_7788, 8'hFF, 64'h0};
      txns[2] = '{1'b1, 64'h8000_2008, 1'b0, 64'h0, 8'h00, 64'hCAFE_BABE_1234_5678, 0,
                  1'b0, 64'h0, 8'h00, 64'hCAFE_BABE_1234_5678};
      txns[3] = '{1'b0, 64'h8000_0004, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h3C, 64'h0000_0413, 1,
                  1'b0, 64'h0, 8'h00, 64'h0000_0413};
      txns[4] = '{1'b1, 64'h8000_3010, 1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 8'h0F, 64'h0000_1234, 1,
                  1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 8'h0F, 64'h0};

      arbs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      arbs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
      arbs[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
      arbs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

      rst = 1'b0;
      if_req_valid = 1'b0; if_addr = 64'h0;
      ls_req_valid = 1'b0; ls_addr = 64'h0; ls_wen = 1'b0; ls_wdata = 64'h0; ls_wmask = 8'h0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_resp_valid", {if_resp_valid, ls_resp_valid}, 2'b00);
      check("rst_if_rdata", if_rdata, 64'h0);
      check("rst_ls_rdata", ls_rdata, 64'h0);
      check("rst_mem_req_valid", mem_req_valid, 1'b0);
      check("rst_mem_addr", mem_addr, 64'h0);
      check("rst_mem_wen", mem_wen, 1'b0);
      check("rst_mem_wdata", mem_wdata, 64'h0);
      check("rst_mem_wmask", mem_wmask, 8'h0);
      check("rst_starve_cnt", u_dut.u_prio.starve_cnt_q, 64'h0);
      rst = 1'b1;
      step();

      // Combinational grant in IDLE; valids are withdrawn before any edge.
      for (int i = 0; i < 4; i++) begin
         if_req_valid = arbs[i].ifv;
         ls_req_valid = arbs[i].lsv;
         #1;
         check("arb_if_ready", if_req_ready, arbs[i].exp_ifr);
         check("arb_ls_ready", ls_req_ready, arbs[i].exp_lsr);
         if_req_valid = 1'b0;
         ls_req_valid = 1'b0;
      end
      step();

      for (int i = 0; i < 5; i++) run_txn(txns[i]);

      // Simultaneous requests: LSU first, IFU after.
      if_addr = 64'h8000_0040; ls_addr = 64'h8000_4000; ls_wen = 1'b0;
      ls_wdata = 64'h0; ls_wmask = 8'h0;
      if_req_valid = 1'b1; ls_req_valid = 1'b1;
      #1;
      check("sim_first_if_ready", if_req_ready, 1'b0);
      check("sim_first_ls_ready", ls_req_ready, 1'b1);
      step();
      ls_req_valid = 1'b0;
      complete(1'b1, 64'h8000_4000, 64'h0000_0000_7777_8888);
      #1;
      check("sim_second_if_ready", if_req_ready, 1'b1);
      check("sim_second_ls_ready", ls_req_ready, 1'b0);
      step();
      if_req_valid = 1'b0;
      complete(1'b0, 64'h8000_0040, 64'h0000_0000_00A0_0093);

      // Starvation: four LSU grants, then the IFU is forced through.
      if_addr = 64'h8000_0080; ls_addr = 64'h8000_5000;
      if_req_valid = 1'b1; ls_req_valid = 1'b1;
      for (int g = 0; g < 5; g++) begin
         exp_ls = (g < 4);
         #1;
         check("starve_if_ready", if_req_ready, !exp_ls);
         check("starve_ls_ready", ls_req_ready, exp_ls);
         step();
         check("starve_cnt", u_dut.u_prio.starve_cnt_q, exp_ls ? 64'(g + 1) : 64'h0);
         complete(exp_ls, exp_ls ? 64'h8000_5000 : 64'h8000_0080, 64'h100 + 64'(g));
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      step();

      // Reset while waiting for the response; the late response must be dropped.
      if_addr = 64'h8000_0100; if_req_valid = 1'b1;
      step();
      if_req_valid = 1'b0; mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      rst = 1'b0;
      exp_if_rdata = 64'h0;
      exp_ls_rdata = 64'h0;
      #1;
      check("arst_req_valid", mem_req_valid, 1'b0);
      check("arst_mem_addr", mem_addr, 64'h0);
      check("arst_if_rdata", if_rdata, 64'h0);
      check("arst_ls_rdata", ls_rdata, 64'h0);
      step();
      rst = 1'b1;
      mem_resp_valid = 1'b1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("arst_stray_resp", {if_resp_valid, ls_resp_valid}, 2'b00);
         check("arst_stray_req", mem_req_valid, 1'b0);
         step();
      end
      mem_resp_valid = 1'b0;
      run_txn(txns[2]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
